// File: rtl/pattern_capture_buffer_pkg.sv
// Shared types and constants for the pattern capture buffer: FSM state encoding,
// default widths and the pointer-width helper.
package pattern_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int PAT_W_DEF = 3;
  localparam int DEPTH_DEF = 8;

  // One extra bit so a pointer can hold DEPTH itself (full / fully drained).
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pattern_capture_buffer_capture_ram.sv
// DEPTH x PAT_W sample store: synchronous write port, registered read port
// whose output holds its last value when no read is issued.
module capture_ram
  import pattern_pkg::*;
#(
  parameter int  PAT_W = PAT_W_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PAT_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PAT_W-1:0] rd_data
);

  logic [PAT_W-1:0] mem [DEPTH];

  // Storage is not reset; its contents only matter after a full capture.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pattern_capture_buffer.sv
// Arms on request, waits for the analyzer match flag, snapshots DEPTH pattern
// samples starting at the trigger cycle, then drains them through a read port.
module pattern_capture_buffer
  import pattern_pkg::*;
#(
  parameter int PAT_W       = PAT_W_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             match_in,
  input  logic             rd_en,
  output logic [PAT_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [1:0]       state_o,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] match_count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0]    LAST_ENTRY  = PW'(DEPTH - 1);
  localparam logic [PW-1:0]    ALL_ENTRIES = PW'(DEPTH);
  localparam logic [TW-1:0]    TIMER_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  cap_state_t    state;
  cap_state_t    state_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] timer;

  logic wr_en;
  logic rd_fire;
  logic expire;
  logic start;
  logic count_en;

  // Read handshake: rd_en is a per-cycle request sampled at the clock edge.
  // A request accepted in DONE (entries remaining, no abort) returns the
  // oldest unread entry on rd_data with rd_valid=1 exactly one cycle later.
  // Any other request is dropped and rd_valid is 0 in the following cycle.

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_fire   = 1'b0;
    expire    = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (arm) begin
            state_nxt = ARMED;
          end
        end
        ARMED: begin
          // A match on the expiry cycle still triggers the capture.
          if (match_in) begin
            state_nxt = CAPTURE;
            wr_en     = 1'b1;
          end else if (timer == TIMER_LAST) begin
            state_nxt = IDLE;
            expire    = 1'b1;
          end
        end
        CAPTURE: begin
          wr_en = 1'b1;
          if (wr_ptr == LAST_ENTRY) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (rd_en && (rd_ptr != ALL_ENTRIES)) begin
            rd_fire = 1'b1;
            if (rd_ptr == LAST_ENTRY) begin
              state_nxt = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign start    = !abort && (state == IDLE) && arm;
  assign count_en = !abort && match_in && ((state == ARMED) || (state == CAPTURE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      timer       <= '0;
      rd_valid    <= 1'b0;
      timeout     <= 1'b0;
      match_count <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (state == ARMED) begin
        timer <= timer + 1'b1;
      end
      if (expire) begin
        timeout <= 1'b1;
      end
      if (count_en && (match_count != CNT_MAX)) begin
        match_count <= match_count + 1'b1;
      end
      // A new window starts from a clean slate.
      if (start) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        timer       <= '0;
        timeout     <= 1'b0;
        match_count <= '0;
      end
      // Abort drops the window but keeps the sticky status for the host.
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        timer  <= '0;
      end
    end
  end

  capture_ram #(
    .PAT_W (PAT_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (pattern_in),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data)
  );

  assign state_o = state;
  assign done    = (state == DONE);

endmodule

// File: tb/tb_pattern_capture_buffer.sv
// Directed bench for pattern_capture_buffer: a queue-based behavioural model
// compared against the outputs every cycle, plus hand-computed checkpoints.
module tb_pattern_capture_buffer;

  localparam int PAT_W       = 3;
  localparam int DEPTH       = 8;
  localparam int TIMEOUT_CYC = 4;
  localparam int CNT_W       = 2;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic             arm        = 1'b0;
  logic             abort      = 1'b0;
  logic [PAT_W-1:0] pattern_in = '0;
  logic             match_in   = 1'b0;
  logic             rd_en      = 1'b0;
  logic [PAT_W-1:0] rd_data;
  logic             rd_valid;
  logic [1:0]       state_o;
  logic             done;
  logic             timeout;
  logic [CNT_W-1:0] match_count;

  int checks = 0;
  int errors = 0;

  logic [PAT_W-1:0] vec1 [8] = '{3'b101, 3'b010, 3'b100, 3'b000, 3'b101, 3'b010, 3'b100, 3'b000};
  logic [PAT_W-1:0] vec3 [8] = '{3'b111, 3'b001, 3'b011, 3'b110, 3'b010, 3'b101, 3'b000, 3'b100};
  logic [PAT_W-1:0] vec6 [8] = '{3'b011, 3'b110, 3'b001, 3'b111, 3'b100, 3'b010, 3'b101, 3'b000};

  pattern_capture_buffer #(
    .PAT_W       (PAT_W),
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .arm         (arm),
    .abort       (abort),
    .pattern_in  (pattern_in),
    .match_in    (match_in),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .state_o     (state_o),
    .done        (done),
    .timeout     (timeout),
    .match_count (match_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phase: 0 idle, 1 waiting for trigger, 2 capturing, 3 holding a capture.
  int               m_phase     = 0;
  int               m_armed_cyc = 0;
  int               m_rd_idx    = 0;
  int               m_count     = 0;
  int               m_rd_valid  = 0;
  int               m_timeout   = 0;
  logic [PAT_W-1:0] m_rd_data   = '0;
  logic [PAT_W-1:0] m_buf [$];

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = 0; m_armed_cyc = 0; m_rd_idx = 0; m_count = 0;
        m_rd_valid = 0; m_timeout = 0; m_rd_data = '0; m_buf.delete();
      end else begin
        m_rd_valid = 0;
        if (abort) begin
          m_phase = 0;
        end else if (m_phase == 0) begin
          if (arm) begin
            m_phase = 1; m_armed_cyc = 0; m_timeout = 0; m_count = 0;
            m_rd_idx = 0; m_buf.delete();
          end
        end else if (m_phase == 1) begin
          m_armed_cyc++;
          if (match_in) begin
            m_count = (m_count < CNT_MAX) ? m_count + 1 : m_count;
            m_buf.push_back(pattern_in);
            m_phase = 2;
          end else if (m_armed_cyc == TIMEOUT_CYC) begin
            m_phase = 0; m_timeout = 1;
          end
        end else if (m_phase == 2) begin
          if (match_in) m_count = (m_count < CNT_MAX) ? m_count + 1 : m_count;
          m_buf.push_back(pattern_in);
          if (m_buf.size() == DEPTH) m_phase = 3;
        end else begin
          if (rd_en) begin
            m_rd_data  = m_buf[m_rd_idx];
            m_rd_valid = 1;
            m_rd_idx++;
            if (m_rd_idx == DEPTH) m_phase = 0;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_state",    int'(state_o),     m_phase);
      check("cmp_done",     int'(done),        (m_phase == 3) ? 1 : 0);
      check("cmp_timeout",  int'(timeout),     m_timeout);
      check("cmp_count",    int'(match_count), m_count);
      check("cmp_rd_valid", int'(rd_valid),    m_rd_valid);
      check("cmp_rd_data",  int'(rd_data),     int'(m_rd_data));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge; applies inputs for the next rising edge.
  task automatic cyc(input logic a, input logic ab, input logic [PAT_W-1:0] p,
                     input logic m, input logic r);
    arm = a; abort = ab; pattern_in = p; match_in = m; rd_en = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic read_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    #1 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_state",    int'(state_o),     0);
    check("rst_rd_valid", int'(rd_valid),    0);
    check("rst_rd_data",  int'(rd_data),     0);
    check("rst_done",     int'(done),        0);
    check("rst_timeout",  int'(timeout),     0);
    check("rst_count",    int'(match_count), 0);
    reset = 1'b1;
    idle(1);

    // 1: basic capture and in-order drain
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("t1_armed", int'(state_o), 1);
    cyc(1'b0, 1'b0, vec1[0], 1'b1, 1'b0);
    check("t1_capture", int'(state_o), 2);
    for (int i = 1; i < 8; i++) begin
      check("t1_not_done_yet", int'(done), 0);
      cyc(1'b0, 1'b0, vec1[i], 1'b0, 1'b0);
    end
    check("t1_done", int'(done), 1);
    check("t1_count", int'(match_count), 1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("t1_rd_valid", int'(rd_valid), 1);
      check("t1_rd_data", int'(rd_data), int'(vec1[i]));
    end
    check("t1_back_idle", int'(state_o), 0);
    idle(1);
    check("t1_rd_valid_drop", int'(rd_valid), 0);

    // 2: timeout after four armed cycles, cleared by the next arm
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    idle(3);
    check("t2_still_armed", int'(state_o), 1);
    idle(1);
    check("t2_idle", int'(state_o), 0);
    check("t2_timeout", int'(timeout), 1);
    check("t2_no_done", int'(done), 0);

    // 3: match on the expiry cycle wins
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("t3_timeout_cleared", int'(timeout), 0);
    idle(3);
    cyc(1'b0, 1'b0, vec3[0], 1'b1, 1'b0);
    check("t3_capture", int'(state_o), 2);
    check("t3_timeout", int'(timeout), 0);
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b0, vec3[i], (i % 3) == 0, 1'b0);
    check("t3_done", int'(done), 1);
    check("t3_count", int'(match_count), 3);
    read_n(4);
    idle(1);
    check("t3_gap_valid", int'(rd_valid), 0);
    check("t3_gap_hold", int'(rd_data), int'(vec3[3]));
    for (int i = 4; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("t3_rd_data", int'(rd_data), int'(vec3[i]));
    end
    check("t3_back_idle", int'(state_o), 0);

    // 4: counter saturation; arm mid-capture is ignored
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(i == 4, 1'b0, 3'(i), 1'b1, 1'b0);
    check("t4_done", int'(done), 1);
    check("t4_saturate", int'(match_count), 3);
    read_n(8);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("t4_idle_rd_ignored", int'(rd_valid), 0);

    // 5: abort on the third capture cycle
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b110, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 3'b010, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 3'b011, 1'b0, 1'b0);
    check("t5_idle", int'(state_o), 0);
    check("t5_no_done", int'(done), 0);
    check("t5_no_timeout", int'(timeout), 0);
    check("t5_count_held", int'(match_count), 1);
    read_n(2);
    check("t5_rd_ignored", int'(rd_valid), 0);

    // 6: reset mid-read, then a full capture after re-arming
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, vec1[0], 1'b1, 1'b0);
    for (int i = 1; i < 8; i++) cyc(1'b0, 1'b0, vec1[i], 1'b1, 1'b0);
    read_n(3);
    check("t6_mid_read_valid", int'(rd_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_valid", int'(rd_valid), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_count", int'(match_count), 0);
    check("t6_rst_state", int'(state_o), 0);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, vec6[0], 1'b1, 1'b0);
    n = 1;
    while (!done && n < 20) begin
      cyc(1'b0, 1'b0, vec6[n % 8], 1'b0, 1'b0);
      n++;
    end
    check("t6_done_reached", int'(done), 1);
    check("t6_capture_len", n, 8);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check("t6_rd_data", int'(rd_data), int'(vec6[i]));
    end
    check("t6_back_idle", int'(state_o), 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
